// File: rtl/cache_pkg.sv
// Shared types and defaults for the data-cache flush path.
// Holds the flush FSM encoding and the CSR address that raises a flush.
package cache_pkg;

    localparam int NUM_SETS_DEF   = 64;
    localparam int LINE_BYTES_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 32;

    localparam logic [11:0] CSR_FLUSH_CACHE = 12'h7C0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB_REQ,
        WB_WAIT,
        INVAL,
        DONE,
        RELEASE
    } flush_state_t;

endpackage

// File: rtl/cache_flush_ctrl.sv
// Walks every data-cache set on a CSR flush request, writing back dirty
// lines and invalidating each set while holding the core stalled.
module cache_flush_ctrl
    import cache_pkg::*;
#(
    parameter  int NUM_SETS   = NUM_SETS_DEF,
    parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter  int LINE_BYTES = LINE_BYTES_DEF,
    localparam int IDX_W      = $clog2(NUM_SETS),
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int TAG_W      = ADDR_WIDTH - IDX_W - OFF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req_i,
    output logic [IDX_W-1:0]      meta_idx_o,
    input  logic                  meta_valid_i,
    input  logic                  meta_dirty_i,
    input  logic [TAG_W-1:0]      meta_tag_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  wb_done_i,
    output logic                  inv_we_o,
    output logic [IDX_W-1:0]      inv_idx_o,
    output logic                  stall_o,
    output logic                  flush_done_o,
    output logic                  csr_clear_o
);

    flush_state_t          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last_set;

    assign last_set = (idx_q == IDX_W'(NUM_SETS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (flush_req_i) state_d = READ;
            READ:    state_d = CHECK;
            CHECK:   state_d = (meta_valid_i && meta_dirty_i) ? WB_REQ : INVAL;
            WB_REQ:  if (wb_ready_i) state_d = WB_WAIT;
            WB_WAIT: if (wb_done_i) state_d = INVAL;
            INVAL:   state_d = last_set ? DONE : READ;
            DONE:    state_d = RELEASE;
            // Hold here until the CSR bit is seen low, so a stale
            // request level cannot start a second walk.
            RELEASE: if (!flush_req_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        if (state_q == IDLE && flush_req_i) begin
            idx_d = '0;
        end
        if (state_q == INVAL && !last_set) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if (state_q == CHECK) begin
            addr_d = {meta_tag_i, idx_q, {OFF_W{1'b0}}};
        end
    end

    always_comb begin
        meta_idx_o   = '0;
        wb_valid_o   = 1'b0;
        wb_addr_o    = addr_q;
        inv_we_o     = 1'b0;
        inv_idx_o    = '0;
        flush_done_o = 1'b0;
        csr_clear_o  = 1'b0;
        stall_o      = 1'b1;
        unique case (state_q)
            IDLE:    stall_o = flush_req_i;
            READ:    meta_idx_o = idx_q;
            WB_REQ:  wb_valid_o = 1'b1;
            INVAL: begin
                inv_we_o  = 1'b1;
                inv_idx_o = idx_q;
            end
            DONE: begin
                flush_done_o = 1'b1;
                csr_clear_o  = 1'b1;
            end
            RELEASE: stall_o = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Scoreboard bench for cache_flush_ctrl with a metadata array model
// and a write-back engine with programmable ready/done delays.
module tb_cache_flush_ctrl;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int LB = 64;
    localparam int IW = 2;
    localparam int OW = 6;
    localparam int TW = AW - IW - OW;

    localparam logic [3:0] K_NONE = 4'd0;
    localparam logic [3:0] K_INV  = 4'd1;
    localparam logic [3:0] K_WB   = 4'd2;
    localparam logic [3:0] K_DONE = 4'd3;

    typedef struct {
        logic [63:0] code;
        bit          dirty;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_req_i;
    logic [IW-1:0] meta_idx_o;
    logic          meta_valid_i;
    logic          meta_dirty_i;
    logic [TW-1:0] meta_tag_i;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [AW-1:0] wb_addr_o;
    logic          wb_done_i;
    logic          inv_we_o;
    logic [IW-1:0] inv_idx_o;
    logic          stall_o;
    logic          flush_done_o;
    logic          csr_clear_o;

    ev_t           exp_q[$];
    int            n_chk;
    int            n_pass;
    int            cyc;
    int            req_cyc;
    int            started;
    int            dones;
    int            aborts;
    int            accepts;
    int            vcnt;
    int            done_cyc;
    int            rw;
    int            dd;
    bit            in_rst;
    logic          mv[NS];
    logic          md[NS];
    logic [TW-1:0] mt[NS];
    logic [IW-1:0] meta_sel;

    cache_flush_ctrl #(
        .NUM_SETS  (NS),
        .ADDR_WIDTH(AW),
        .LINE_BYTES(LB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req_i (flush_req_i),
        .meta_idx_o  (meta_idx_o),
        .meta_valid_i(meta_valid_i),
        .meta_dirty_i(meta_dirty_i),
        .meta_tag_i  (meta_tag_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_done_i   (wb_done_i),
        .inv_we_o    (inv_we_o),
        .inv_idx_o   (inv_idx_o),
        .stall_o     (stall_o),
        .flush_done_o(flush_done_o),
        .csr_clear_o (csr_clear_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        meta_sel <= meta_idx_o;
    end

    assign meta_valid_i = mv[meta_sel];
    assign meta_dirty_i = md[meta_sel];
    assign meta_tag_i   = mt[meta_sel];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] mk(input logic [3:0] k,
                                       input logic [31:0] v);
        return {28'd0, k, v};
    endfunction

    task automatic pop_exp(output ev_t e);
        if (exp_q.size() == 0) begin
            e.code  = mk(K_NONE, 32'd0);
            e.dirty = 1'b0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Write-back engine: ready after rw stalled cycles, done dd cycles
    // after acceptance.
    initial begin
        int rcnt;
        int wcnt;
        bit waiting;
        rcnt    = 0;
        wcnt    = 0;
        waiting = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                wb_ready_i = 1'b0;
                wb_done_i  = 1'b0;
                waiting    = 0;
                rcnt       = 0;
            end else begin
                wb_done_i = 1'b0;
                if (waiting) begin
                    if (wcnt == 0) begin
                        wb_done_i = 1'b1;
                        waiting   = 0;
                    end else begin
                        wcnt--;
                    end
                end else if (wb_ready_i) begin
                    wb_ready_i = 1'b0;
                    waiting    = 1;
                    wcnt       = dd - 2;
                end else if (wb_valid_o) begin
                    if (rcnt >= rw) begin
                        wb_ready_i = 1'b1;
                        rcnt       = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (!in_rst) begin
            chk("stall", 64'(stall_o), 64'(started != dones + aborts));
            if (wb_valid_o) begin
                vcnt++;
                if (exp_q.size() == 0)
                    chk("wb_spur", 64'(1), 64'(0));
                else
                    chk("wb_addr", mk(K_WB, wb_addr_o), exp_q[0].code);
                if (wb_ready_i) begin
                    pop_exp(e);
                    chk("wb_acc", mk(K_WB, wb_addr_o), e.code);
                    chk("wb_hold", 64'(vcnt), 64'(rw + 1));
                    vcnt = 0;
                    accepts++;
                end
            end
            if (wb_done_i) done_cyc = cyc;
            if (inv_we_o) begin
                pop_exp(e);
                chk("inv", mk(K_INV, 32'(inv_idx_o)), e.code);
                if (e.dirty)
                    chk("inv_lat", 64'(cyc), 64'(done_cyc + 1));
            end
            if (flush_done_o) begin
                pop_exp(e);
                chk("done", mk(K_DONE, 32'(cyc - req_cyc)), e.code);
                chk("csr_clr", 64'(csr_clear_o), 64'(1));
                dones++;
            end else if (csr_clear_o) begin
                chk("clr_spur", 64'(1), 64'(0));
            end
        end
    end

    task automatic build_exp();
        int len;
        logic [31:0] a;
        len = 1;
        for (int i = 0; i < NS; i++) begin
            if (mv[i] && md[i]) begin
                a = (32'(mt[i]) << (IW + OW)) | (32'(i) << OW);
                exp_q.push_back('{mk(K_WB, a), 1'b0});
                exp_q.push_back('{mk(K_INV, 32'(i)), 1'b1});
                len += 4 + rw + dd;
            end else begin
                exp_q.push_back('{mk(K_INV, 32'(i)), 1'b0});
                len += 3;
            end
        end
        exp_q.push_back('{mk(K_DONE, 32'(len)), 1'b0});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NS; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
    endtask

    task automatic do_reset(input int n);
        in_rst      = 1;
        rst_n       = 1'b0;
        flush_req_i = 1'b0;
        if (started != dones + aborts) aborts++;
        exp_q.delete();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_meta", 64'(meta_idx_o), 64'(0));
        chk("rst_wbv", 64'(wb_valid_o), 64'(0));
        chk("rst_wba", 64'(wb_addr_o), 64'(0));
        chk("rst_inv", 64'(inv_we_o), 64'(0));
        chk("rst_invi", 64'(inv_idx_o), 64'(0));
        chk("rst_done", 64'(flush_done_o), 64'(0));
        chk("rst_clr", 64'(csr_clear_o), 64'(0));
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        in_rst = 0;
    endtask

    task automatic walk(input int drop_at, input int hold);
        int d0;
        bit got;
        got = 0;
        build_exp();
        @(posedge clk);
        #3;
        d0          = dones;
        flush_req_i = 1'b1;
        req_cyc     = cyc;
        started++;
        #1 chk("stall_c0", 64'(stall_o), 64'(1));
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #3;
            if (drop_at > 0 && cyc == req_cyc + drop_at)
                flush_req_i = 1'b0;
            got = (dones != d0);
        end
        chk("walk_end", 64'(got), 64'(1));
        if (!got) begin
            do_reset(2);
        end else begin
            repeat (hold) begin
                @(posedge clk);
                #3;
            end
            flush_req_i = 1'b0;
        end
        chk("q_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int a0;
        n_chk       = 0;
        n_pass      = 0;
        started     = 0;
        dones       = 0;
        aborts      = 0;
        accepts     = 0;
        vcnt        = 0;
        done_cyc    = -100;
        rw          = 0;
        dd          = 2;
        in_rst      = 1;
        rst_n       = 1'b0;
        flush_req_i = 1'b0;
        wb_ready_i  = 1'b0;
        wb_done_i   = 1'b0;
        clear_mem();
        do_reset(3);

        // all lines invalid
        walk(0, 0);

        // set 1 clean, set 2 dirty; request held after done
        mv[1] = 1'b1; md[1] = 1'b0; mt[1] = 24'h000ABC;
        mv[2] = 1'b1; md[2] = 1'b1; mt[2] = 24'h012345;
        rw = 2;
        dd = 5;
        walk(0, 10);

        // two dirty lines, a dirty-but-invalid line, request dropped early
        clear_mem();
        mv[0] = 1'b1; md[0] = 1'b1; mt[0] = 24'hFFFFFF;
        mv[1] = 1'b0; md[1] = 1'b1; mt[1] = 24'h00BEEF;
        mv[3] = 1'b1; md[3] = 1'b1; mt[3] = 24'h00A5A5;
        rw = 1;
        dd = 2;
        walk(3, 0);

        // reset while waiting for write-back completion
        clear_mem();
        mv[2] = 1'b1; md[2] = 1'b1; mt[2] = 24'h000055;
        rw = 0;
        dd = 30;
        build_exp();
        @(posedge clk);
        #3;
        d0          = dones;
        a0          = accepts;
        flush_req_i = 1'b1;
        req_cyc     = cyc;
        started++;
        for (int i = 0; i < 100 && accepts == a0; i++) begin
            @(posedge clk);
            #3;
        end
        chk("wb_accepted", 64'(accepts != a0), 64'(1));
        repeat (2) begin
            @(posedge clk);
            #3;
        end
        do_reset(1);
        repeat (40) @(posedge clk);
        #3;
        chk("no_done", 64'(dones), 64'(d0));

        // fresh walk after reset starts from set 0
        clear_mem();
        dd = 2;
        walk(0, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
